// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: FSM state type and
// address-field width helpers used by assoc_cache and cache_way.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        REFILL = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } cacheState_t;

    function automatic int offsetBits(input int lineWords);
        return $clog2(lineWords);
    endfunction

    function automatic int indexBits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagBits(input int addrW, input int lineWords, input int sets);
        return addrW - $clog2(lineWords) - $clog2(sets);
    endfunction

    // A direct-mapped build still needs a one-bit pointer/victim field.
    function automatic int wayBits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Word address of the first word in the line containing addr.
    function automatic logic [63:0] lineBase(input logic [63:0] addr, input int offW);
        return (addr >> offW) << offW;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid bit, tag and line data, with a
// tag-match output for the set currently being looked up.
module cache_way #(
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 32,
    parameter int OFF_W      = 2,
    parameter int IDX_W      = 5,
    parameter int TAG_W      = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    input  logic [OFF_W-1:0]  rdOff,
    input  logic              wrEn,
    input  logic [OFF_W-1:0]  wrOff,
    input  logic [DATA_W-1:0] wrData,
    input  logic              setValid,
    output logic              hit,
    output logic              lineValid,
    output logic [DATA_W-1:0] rdWord
);

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [DATA_W-1:0] data [SETS][LINE_WORDS];

    // Valid bits are the only state that must be cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (setValid) begin
            valid[idx] <= 1'b1;
        end
    end

    // Tag and word storage; the tag is captured when the line is validated.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            data[idx][wrOff] <= wrData;
        end
        if (setValid) begin
            tags[idx] <= tag;
        end
    end

    assign lineValid = valid[idx];
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign rdWord    = data[idx][rdOff];

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative, write-through / no-write-allocate cache with a
// word-serial refill port and per-set round-robin replacement.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
//
// state  | meaning
// IDLE   | ready for a new CPU request
// LOOKUP | tag compare against every way of the set
// REFILL | fetching the victim line word by word from memory
// WRITE  | write-through to memory, held until accepted
// RESP   | one-cycle completion pulse for refills and writes
module assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 32,
    parameter int WAYS       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W = offsetBits(LINE_WORDS);
    localparam int IDX_W = indexBits(SETS);
    localparam int TAG_W = tagBits(ADDR_W, LINE_WORDS, SETS);
    localparam int WAY_W = wayBits(WAYS);

    cacheState_t       state;
    logic [ADDR_W-1:0] reqAddrR;
    logic              reqWeR;
    logic [DATA_W-1:0] reqWdataR;
    logic [OFF_W-1:0]  wordCnt;
    logic              reqSent;
    logic [WAY_W-1:0]  victimR;
    logic [WAY_W-1:0]  rrPtr [SETS];

    logic [OFF_W-1:0]  offR;
    logic [IDX_W-1:0]  idxR;
    logic [TAG_W-1:0]  tagR;

    logic [WAYS-1:0]   wayHit, wayValid, wrEn, setValid;
    logic [DATA_W-1:0] wayWord [WAYS];
    logic [OFF_W-1:0]  wrOff;
    logic [DATA_W-1:0] wrData;

    logic              anyHit;
    logic [DATA_W-1:0] hitWord;
    logic [WAY_W-1:0]  victimSel;
    logic              memHs, wordDone, lastWord;

    assign offR = reqAddrR[OFF_W-1:0];
    assign idxR = reqAddrR[OFF_W +: IDX_W];
    assign tagR = reqAddrR[ADDR_W-1 -: TAG_W];

    for (genvar g = 0; g < WAYS; g++) begin : gWay
        cache_way #(
            .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS),
            .OFF_W(OFF_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
        ) uWay (
            .clk(clk), .reset(reset), .idx(idxR), .tag(tagR), .rdOff(offR),
            .wrEn(wrEn[g]), .wrOff(wrOff), .wrData(wrData), .setValid(setValid[g]),
            .hit(wayHit[g]), .lineValid(wayValid[g]), .rdWord(wayWord[g])
        );
    end

    // Hit detection; at most one way matches so OR-ing the words is a mux.
    always_comb begin
        anyHit  = 1'b0;
        hitWord = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (wayHit[w]) begin
                anyHit  = 1'b1;
                hitWord = hitWord | wayWord[w];
            end
        end
    end

    // Victim: lowest-numbered invalid way, else the set's round-robin way.
    always_comb begin
        logic found;
        found     = 1'b0;
        victimSel = rrPtr[idxR];
        for (int w = 0; w < WAYS; w++) begin
            if (!wayValid[w] && !found) begin
                found     = 1'b1;
                victimSel = WAY_W'(w);
            end
        end
    end

    // A refill word completes when data returns for the outstanding request,
    // which may be in the same cycle the request is accepted.
    assign memHs    = mem_req_valid && mem_req_ready;
    assign wordDone = (state == REFILL) && mem_rsp_valid && (reqSent || memHs);
    assign lastWord = wordDone && (wordCnt == OFF_W'(LINE_WORDS - 1));

    // Storage write steering: write hits update one word, refills stream in.
    always_comb begin
        wrEn     = '0;
        setValid = '0;
        wrOff    = offR;
        wrData   = reqWdataR;
        if (state == LOOKUP && reqWeR) begin
            wrEn = wayHit;
        end else if (wordDone) begin
            wrEn[victimR]     = 1'b1;
            setValid[victimR] = lastWord;
            wrOff             = wordCnt;
            wrData            = mem_rsp_data;
        end
    end

    // Miss-handling state machine and per-set replacement pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            reqAddrR  <= '0;
            reqWeR    <= 1'b0;
            reqWdataR <= '0;
            wordCnt   <= '0;
            reqSent   <= 1'b0;
            victimR   <= '0;
            for (int s = 0; s < SETS; s++) begin
                rrPtr[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        reqAddrR  <= req_addr;
                        reqWeR    <= req_we;
                        reqWdataR <= req_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (reqWeR) begin
                        state <= WRITE;
                    end else if (anyHit) begin
                        state <= IDLE;
                    end else begin
                        victimR <= victimSel;
                        wordCnt <= '0;
                        reqSent <= 1'b0;
                        state   <= REFILL;
                    end
                end
                REFILL: begin
                    if (wordDone) begin
                        reqSent <= 1'b0;
                        wordCnt <= wordCnt + 1'b1;
                        if (lastWord) begin
                            rrPtr[idxR] <= WAY_W'((int'(rrPtr[idxR]) + 1) % WAYS);
                            state       <= RESP;
                        end
                    end else if (memHs) begin
                        reqSent <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_req_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Read lookups bump exactly one counter; both stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && !reqWeR) begin
            if (anyHit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

    assign req_ready     = (state == IDLE);
    assign stall         = (state != IDLE);
    assign rsp_valid     = ((state == LOOKUP) && !reqWeR && anyHit) || (state == RESP);
    assign rsp_rdata     = ((state == LOOKUP) && !reqWeR && anyHit) ? hitWord :
                           ((state == RESP) && !reqWeR)             ? wayWord[victimR] : '0;
    assign mem_req_valid = ((state == REFILL) && !reqSent) || (state == WRITE);
    assign mem_req_we    = (state == WRITE);
    assign mem_req_wdata = (state == WRITE) ? reqWdataR : '0;
    assign mem_req_addr  = (state == REFILL) ? (ADDR_W'(lineBase(64'(reqAddrR), OFF_W)) | ADDR_W'(wordCnt)) :
                           (state == WRITE)  ? reqAddrR : '0;

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache (default parameters): directed scenarios plus
// randomized traffic against a behavioural model of sets, tags and memory.
module tb_assoc_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        stall;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr;
    logic [7:0]  mem_req_wdata;
    logic        mem_rsp_valid;
    logic [7:0]  mem_rsp_data;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    assoc_cache dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } memOp_t;

    memOp_t     memLog [$];
    logic [7:0] memW [logic [31:0]];
    bit         randWait = 1'b0;
    int         holdTarget = 0;
    int         holdsDone = 0;

    // Model: 32 sets x 2 ways, 4-word lines.
    bit          mValid [32][2];
    logic [31:0] mTag   [32][2];
    int          mPtr   [32];

    function automatic logic [7:0] memVal(input logic [31:0] a);
        if (memW.exists(a)) return memW[a];
        return a[7:0] ^ 8'hE0;
    endfunction

    function automatic void modelReset();
        for (int s = 0; s < 32; s++) begin
            mPtr[s] = 0;
            for (int w = 0; w < 2; w++) begin
                mValid[s][w] = 1'b0;
                mTag[s][w]   = '0;
            end
        end
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        int s;
        s = int'((a >> 2) & 32'h1F);
        for (int w = 0; w < 2; w++)
            if (mValid[s][w] && mTag[s][w] == (a >> 7)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void modelFill(input logic [31:0] a);
        int s, v;
        s = int'((a >> 2) & 32'h1F);
        v = mPtr[s];
        if (!mValid[s][1]) v = 1;
        if (!mValid[s][0]) v = 0;
        mValid[s][v] = 1'b1;
        mTag[s][v]   = a >> 7;
        mPtr[s]      = (mPtr[s] + 1) % 2;
    endfunction

    // Memory responder: accepts and answers reads in the same cycle unless
    // a forced hold or random wait is requested.
    always @(negedge clk) begin
        if (mem_req_valid && holdsDone < holdTarget) begin
            mem_req_ready = 1'b0;
            holdsDone++;
        end else if (mem_req_valid && randWait && $urandom_range(0, 1) == 0) begin
            mem_req_ready = 1'b0;
        end else begin
            mem_req_ready = mem_req_valid;
        end
        mem_rsp_valid = mem_req_ready && !mem_req_we;
        mem_rsp_data  = mem_rsp_valid ? memVal(mem_req_addr) : 8'h00;
    end

    // Log every accepted memory request; writes update backing memory.
    always @(posedge clk) begin
        if (!reset && mem_req_valid && mem_req_ready) begin
            memLog.push_back('{mem_req_we, mem_req_addr, mem_req_wdata});
            if (mem_req_we) memW[mem_req_addr] = mem_req_wdata;
        end
    end

    task automatic applyReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [7:0] wd);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Runs one request; lat counts cycles from acceptance to rsp_valid (-1 on timeout).
    task automatic runReq(input logic [31:0] a, input logic we, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat, output int logStart);
        logStart = memLog.size();
        issue(a, we, wd);
        rd  = '0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 300);
        if (rsp_valid) rd = rsp_rdata;
        else lat = -1;
    endtask

    task automatic test_reset();
        applyReset();
        #1;
        nChecks++;
        if ({req_ready, rsp_valid, stall, mem_req_valid, mem_req_we} !== 5'b10000) begin
            nFails++;
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, rsp_valid, stall, mem_req_valid, mem_req_we});
        end
        nChecks++;
        if ({rsp_rdata, mem_req_addr, mem_req_wdata} !== 48'h0) begin
            nFails++;
            $display("FAIL reset_data: rdata=%h maddr=%h mwdata=%h want 0", rsp_rdata, mem_req_addr, mem_req_wdata);
        end
    endtask

    task automatic test_refill_hit();
        logic [7:0] rd; int lat, ls;
        runReq(32'h40, 1'b0, 8'h00, rd, lat, ls);
        modelFill(32'h40);
        nChecks++;
        if (rd !== 8'hA0 || lat !== 6) begin
            nFails++;
            $display("FAIL miss_0x40: rdata=%h lat=%0d want A0 lat 6", rd, lat);
        end
        nChecks++;
        if (memLog.size() - ls !== 4) begin
            nFails++;
            $display("FAIL miss_0x40_count: got %0d mem ops want 4", memLog.size() - ls);
        end else begin
            for (int k = 0; k < 4; k++) begin
                nChecks++;
                if (memLog[ls+k].we !== 1'b0 || memLog[ls+k].addr !== 32'h40 + 32'(k)) begin
                    nFails++;
                    $display("FAIL miss_0x40_addr%0d: we=%b addr=%h want 0 %h", k, memLog[ls+k].we, memLog[ls+k].addr, 32'h40 + 32'(k));
                end
            end
        end
        runReq(32'h42, 1'b0, 8'h00, rd, lat, ls);
        nChecks++;
        if (rd !== 8'hA2 || lat !== 1 || memLog.size() !== ls) begin
            nFails++;
            $display("FAIL hit_0x42: rdata=%h lat=%0d memops=%0d want A2 lat 1 no memops", rd, lat, memLog.size() - ls);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; int lat, ls;
        runReq(32'h43, 1'b0, 8'h00, rd, lat, ls);
        nChecks++;
        if (rd !== 8'hA3 || req_ready !== 1'b0) begin
            nFails++;
            $display("FAIL b2b_pulse: rdata=%h ready=%b want A3 ready 0", rd, req_ready);
        end
        @(negedge clk);
        nChecks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nFails++;
            $display("FAIL b2b_after: ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_eviction();
        logic [7:0] rd; int lat, ls;
        logic [31:0] seq [5];
        int          expLat [5];
        applyReset();
        seq = '{32'h000, 32'h080, 32'h100, 32'h080, 32'h000};
        expLat = '{6, 6, 6, 1, 6};
        for (int i = 0; i < 5; i++) begin
            runReq(seq[i], 1'b0, 8'h00, rd, lat, ls);
            nChecks++;
            if (lat !== (modelHit(seq[i]) ? 1 : 6) || lat !== expLat[i] || rd !== memVal(seq[i])) begin
                nFails++;
                $display("FAIL evict_step%0d: addr=%h lat=%0d rdata=%h want lat %0d rdata %h", i, seq[i], lat, rd, expLat[i], memVal(seq[i]));
            end
            if (!modelHit(seq[i])) modelFill(seq[i]);
        end
    endtask

    task automatic test_write();
        logic [7:0] rd; int lat, ls;
        applyReset();
        runReq(32'h40, 1'b0, 8'h00, rd, lat, ls);
        modelFill(32'h40);
        runReq(32'h41, 1'b1, 8'h55, rd, lat, ls);
        nChecks++;
        if (memLog.size() - ls !== 1 || memLog[ls].we !== 1'b1 || memLog[ls].addr !== 32'h41 || memLog[ls].data !== 8'h55) begin
            nFails++;
            $display("FAIL write_hit_mem: ops=%0d last we/addr/data=%b %h %h want 1 op 1 41 55",
                     memLog.size() - ls, memLog[$].we, memLog[$].addr, memLog[$].data);
        end
        nChecks++;
        if (rd !== 8'h00 || lat !== 3) begin
            nFails++;
            $display("FAIL write_rsp: rdata=%h lat=%0d want 00 lat 3", rd, lat);
        end
        runReq(32'h41, 1'b0, 8'h00, rd, lat, ls);
        nChecks++;
        if (rd !== 8'h55 || lat !== 1) begin
            nFails++;
            $display("FAIL write_hit_read: rdata=%h lat=%0d want 55 lat 1", rd, lat);
        end
        runReq(32'h200, 1'b1, 8'h3C, rd, lat, ls);
        nChecks++;
        if (memLog.size() - ls !== 1 || memLog[ls].addr !== 32'h200 || memLog[ls].data !== 8'h3C) begin
            nFails++;
            $display("FAIL write_miss_mem: ops=%0d addr=%h data=%h want 1 op 200 3C", memLog.size() - ls, memLog[$].addr, memLog[$].data);
        end
        runReq(32'h200, 1'b0, 8'h00, rd, lat, ls);
        modelFill(32'h200);
        nChecks++;
        if (rd !== 8'h3C || lat !== 6 || memLog.size() - ls !== 4) begin
            nFails++;
            $display("FAIL write_miss_read: rdata=%h lat=%0d ops=%0d want 3C lat 6 ops 4", rd, lat, memLog.size() - ls);
        end
    endtask

    task automatic test_mem_stall();
        int lat, ls, bad;
        ls = memLog.size();
        holdTarget = holdsDone + 5;
        issue(32'h300, 1'b0, 8'h00);
        @(negedge clk);
        lat = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            lat++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300 || stall !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        nChecks++;
        if (bad !== 0) begin
            nFails++;
            $display("FAIL stall_hold: %0d bad cycles (valid=%b addr=%h stall=%b rsp=%b)", bad, mem_req_valid, mem_req_addr, stall, rsp_valid);
        end
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        modelFill(32'h300);
        nChecks++;
        if (rsp_valid !== 1'b1 || lat !== 11 || rsp_rdata !== memVal(32'h300) || memLog.size() - ls !== 4) begin
            nFails++;
            $display("FAIL stall_done: rsp=%b lat=%0d rdata=%h ops=%0d want 1 lat 11 %h ops 4",
                     rsp_valid, lat, rsp_rdata, memLog.size() - ls, memVal(32'h300));
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [7:0] rd; int lat, ls, guard;
        ls = memLog.size();
        issue(32'h500, 1'b0, 8'h00);
        guard = 0;
        while (memLog.size() - ls < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        reset = 1'b1;
        #1;
        nChecks++;
        if (guard >= 50 || {req_ready, rsp_valid, stall, mem_req_valid, mem_req_we} !== 5'b10000 ||
            {rsp_rdata, mem_req_addr, mem_req_wdata} !== 48'h0) begin
            nFails++;
            $display("FAIL midreset_outputs: guard=%0d ready=%b rsp=%b stall=%b mvalid=%b maddr=%h",
                     guard, req_ready, rsp_valid, stall, mem_req_valid, mem_req_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        runReq(32'h500, 1'b0, 8'h00, rd, lat, ls);
        modelFill(32'h500);
        nChecks++;
        if (memLog.size() - ls !== 4 || lat !== 6 || rd !== memVal(32'h500)) begin
            nFails++;
            $display("FAIL midreset_refill: ops=%0d lat=%0d rdata=%h want 4 lat 6 %h", memLog.size() - ls, lat, rd, memVal(32'h500));
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        logic [7:0] rd; int lat, ls;
        applyReset();
        runReq(32'h40, 1'b0, 8'h00, rd, lat, ls);
        modelFill(32'h40);
        runReq(32'h41, 1'b0, 8'h00, rd, lat, ls);
        runReq(32'h42, 1'b0, 8'h00, rd, lat, ls);
        runReq(32'h43, 1'b1, 8'h77, rd, lat, ls);
        @(negedge clk);
        nChecks++;
        if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
            nFails++;
            $display("FAIL stats: hits=%0d misses=%0d want 2 1", hit_count, miss_count);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        logic        we;
        logic [7:0]  wd, rd, expData;
        int          lat, ls, expOps;
        bit          hit;
        randWait = 1'b1;
        for (int n = 0; n < 150; n++) begin
            a  = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            we = ($urandom_range(0, 3) == 0);
            wd = 8'($urandom);
            hit = modelHit(a);
            runReq(a, we, wd, rd, lat, ls);
            expData = we ? 8'h00 : memVal(a);
            expOps  = we ? 1 : (hit ? 0 : 4);
            nChecks++;
            if (lat < 0 || rd !== expData) begin
                nFails++;
                $display("FAIL rand%0d_data: addr=%h we=%b rdata=%h lat=%0d want %h", n, a, we, rd, lat, expData);
            end
            nChecks++;
            if (memLog.size() - ls !== expOps) begin
                nFails++;
                $display("FAIL rand%0d_ops: addr=%h we=%b ops=%0d want %0d", n, a, we, memLog.size() - ls, expOps);
            end else begin
                for (int k = 0; k < expOps; k++) begin
                    nChecks++;
                    if (memLog[ls+k].we !== we ||
                        memLog[ls+k].addr !== (we ? a : ((a & 32'hFFFF_FFFC) + 32'(k))) ||
                        (we && memLog[ls+k].data !== wd)) begin
                        nFails++;
                        $display("FAIL rand%0d_op%0d: we=%b addr=%h data=%h for req addr=%h", n, k,
                                 memLog[ls+k].we, memLog[ls+k].addr, memLog[ls+k].data, a);
                    end
                end
            end
            if (!we && !hit) modelFill(a);
        end
        randWait = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        modelReset();
        test_reset();
        test_refill_hit();
        test_back_to_back();
        test_eviction();
        test_write();
        test_mem_stall();
        test_reset_mid_refill();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        applyReset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
